// File: rtl/serv_ext_seq.sv
// Sequencer between the bit-serial SERV core and a 32-bit parallel extension unit (FPU).
// Optional WAIT watchdog is enabled by defining SERV_EXT_TMO_EN.
//
// state   | meaning
// IDLE    | waiting for i_valid, operands latched on accept
// ISSUE   | request presented to the unit until i_unit_ready
// WAIT    | waiting for the unit result (or watchdog expiry)
// DONE    | result loaded, o_ready pulse
// SHIFT   | result streamed LSB first, one bit per i_rd_en
module serv_ext_seq #(
    parameter int OPW     = 5,
    parameter int TMO_MAX = 255
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_valid,
    input  logic [OPW-1:0] i_op,
    input  logic [31:0]    i_rs1,
    input  logic [31:0]    i_rs2,
    output logic           o_busy,
    output logic           o_ready,
    input  logic           i_rd_en,
    output logic           o_rd,
    output logic           o_unit_valid,
    output logic [OPW-1:0] o_unit_op,
    output logic [31:0]    o_unit_a,
    output logic [31:0]    o_unit_b,
    input  logic           i_unit_ready,
    input  logic           i_res_valid,
    input  logic [31:0]    i_res,
    input  logic [4:0]     i_res_flags,
    input  logic           i_fflags_clr,
    output logic [4:0]     o_fflags,
    output logic           o_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_SHIFT = 3'd4
    } state_t;

    state_t state, state_nx;

    logic [OPW-1:0] op_q;
    logic [31:0]    a_q, b_q, shreg;
    logic [4:0]     bit_cnt;
    logic [4:0]     fflags;

    logic take, handshake, res_load, tmo_hit, shift_en, last_bit;

    assign take      = (state == S_IDLE) && i_valid;
    assign handshake = (state == S_ISSUE) && i_unit_ready;
    assign res_load  = (state == S_WAIT) && i_res_valid;
    assign shift_en  = (state == S_SHIFT) && i_rd_en;
    assign last_bit  = shift_en && (bit_cnt == 5'd31);

`ifdef SERV_EXT_TMO_EN
    localparam logic [7:0] TMO_LOAD = 8'(TMO_MAX - 1);

    // Down-counter loaded on the handshake so it holds TMO_MAX-1 in the first WAIT cycle.
    logic [7:0] tmo;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            tmo <= 8'd0;
        else if (handshake)
            tmo <= TMO_LOAD;
        else if ((state == S_WAIT) && (tmo != 8'd0))
            tmo <= tmo - 8'd1;
    end

    assign tmo_hit = (state == S_WAIT) && !i_res_valid && (tmo == 8'd0);
`else
    logic unused_tmo;
    assign unused_tmo = (TMO_MAX > 0);
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (i_valid)                 state_nx = S_ISSUE;
            S_ISSUE: if (i_unit_ready)            state_nx = S_WAIT;
            S_WAIT:  if (i_res_valid || tmo_hit)  state_nx = S_DONE;
            S_DONE:                               state_nx = S_SHIFT;
            S_SHIFT: if (last_bit)                state_nx = S_IDLE;
            default:                              state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy       = 1'b0;
        o_ready      = 1'b0;
        o_unit_valid = 1'b0;
        o_rd         = 1'b0;
        o_err        = 1'b0;
        case (state)
            S_IDLE:  ;
            S_ISSUE: begin
                o_busy       = 1'b1;
                o_unit_valid = 1'b1;
            end
            S_WAIT: begin
                o_busy = 1'b1;
                o_err  = tmo_hit;
            end
            S_DONE: begin
                o_busy  = 1'b1;
                o_ready = 1'b1;
            end
            S_SHIFT: begin
                o_busy = 1'b1;
                o_rd   = shreg[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            op_q <= '0;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
        end else if (take) begin
            op_q <= i_op;
            a_q  <= i_rs1;
            b_q  <= i_rs2;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shreg   <= 32'd0;
            bit_cnt <= 5'd0;
        end else if (res_load) begin
            shreg <= i_res;
        end else if (tmo_hit) begin
            shreg <= 32'h7FC0_0000;
        end else if (shift_en) begin
            shreg   <= {1'b0, shreg[31:1]};
            bit_cnt <= bit_cnt + 5'd1;
        end
    end

    // A load in the same cycle as a clear keeps the newly raised bits.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            fflags <= 5'd0;
        else
            fflags <= (i_fflags_clr ? 5'd0 : fflags)
                    | (res_load ? i_res_flags : 5'd0)
                    | (tmo_hit ? 5'b10000 : 5'd0);
    end

    assign o_unit_op = op_q;
    assign o_unit_a  = a_q;
    assign o_unit_b  = b_q;
    assign o_fflags  = fflags;

endmodule
